// File: rtl/bin_to_bcd_digits.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_digits
//
// Sequential double-dabble converter: turns an unsigned binary value into four
// BCD digits for a 4-digit seven-segment display driver. One shift per input
// bit, then a single DONE cycle that loads the output digits. Values above
// 9999 saturate the display to 9999 and raise o_Overflow.
//
// Ports:
//   i_Clk       system clock, rising edge
//   i_Reset     synchronous, active-high reset
//   i_Start     conversion request, sampled only while idle
//   i_Binary    unsigned value, captured on the accepted start edge
//   o_Digit_1   ones digit (rightmost anode), BCD 0..9
//   o_Digit_2   tens digit
//   o_Digit_3   hundreds digit
//   o_Digit_4   thousands digit
//   o_Busy      conversion in progress
//   o_Done      one-cycle pulse, new digits valid
//   o_Overflow  last converted value exceeded 9999
// -----------------------------------------------------------------------------
module bin_to_bcd_digits #(
   parameter int c_Input_Width = 14
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset,
   input  logic                     i_Start,
   input  logic [c_Input_Width-1:0] i_Binary,
   output logic [3:0]               o_Digit_1,
   output logic [3:0]               o_Digit_2,
   output logic [3:0]               o_Digit_3,
   output logic [3:0]               o_Digit_4,
   output logic                     o_Busy,
   output logic                     o_Done,
   output logic                     o_Overflow
);

   localparam int                 CNT_W     = $clog2(c_Input_Width + 1);
   localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(c_Input_Width);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(1);
   localparam logic [31:0]        MAX_SHOWN = 32'd9999;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                     state_r;
   logic [c_Input_Width-1:0]   bin_r;
   logic [c_Input_Width-1:0]   captured_r;
   logic [15:0]                bcd_r;
   logic [CNT_W-1:0]           count_r;
   logic [3:0]                 digit_1_r;
   logic [3:0]                 digit_2_r;
   logic [3:0]                 digit_3_r;
   logic [3:0]                 digit_4_r;
   logic                       busy_r;
   logic                       done_r;
   logic                       overflow_r;

   logic [15:0]                bcd_next_s;
   logic [c_Input_Width-1:0]   bin_next_s;
   logic                       overflow_s;

   // Add 3 to a BCD nibble that is 5 or more so the following shift carries
   // correctly into the next decade.
   function automatic logic [3:0] dabble_nibble(input logic [3:0] nib);
      logic [3:0] res;
      if (nib >= 4'd5) begin
         res = nib + 4'd3;
      end else begin
         res = nib;
      end
      return res;
   endfunction

   // Adjust all four nibbles on the pre-shift value, then shift in the next
   // binary MSB. The bit shifted out of the top nibble only occurs for values
   // above 9999, which are saturated separately.
   function automatic logic [15:0] dabble_shift(input logic [15:0] bcd,
                                                input logic        msb);
      logic [15:0] adj;
      adj = {dabble_nibble(bcd[15:12]), dabble_nibble(bcd[11:8]),
             dabble_nibble(bcd[7:4]),   dabble_nibble(bcd[3:0])};
      return {adj[14:0], msb};
   endfunction

   // Next accumulator / binary shift values and overflow decision.
   always_comb begin
      bcd_next_s = dabble_shift(bcd_r, bin_r[c_Input_Width-1]);
      bin_next_s = {bin_r[c_Input_Width-2:0], 1'b0};
      overflow_s = (32'(captured_r) > MAX_SHOWN);
   end

   // Conversion FSM with registered digits and status flags.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_r    <= IDLE;
         bin_r      <= '0;
         captured_r <= '0;
         bcd_r      <= 16'd0;
         count_r    <= '0;
         digit_1_r  <= 4'd0;
         digit_2_r  <= 4'd0;
         digit_3_r  <= 4'd0;
         digit_4_r  <= 4'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (i_Start) begin
                  bin_r      <= i_Binary;
                  captured_r <= i_Binary;
                  bcd_r      <= 16'd0;
                  count_r    <= CNT_LOAD;
                  busy_r     <= 1'b1;
                  state_r    <= SHIFT;
               end else begin
                  state_r    <= IDLE;
               end
            end
            SHIFT: begin
               bcd_r   <= bcd_next_s;
               bin_r   <= bin_next_s;
               count_r <= count_r - CNT_LAST;
               if (count_r == CNT_LAST) begin
                  state_r <= DONE;
               end else begin
                  state_r <= SHIFT;
               end
            end
            DONE: begin
               if (overflow_s) begin
                  digit_1_r <= 4'd9;
                  digit_2_r <= 4'd9;
                  digit_3_r <= 4'd9;
                  digit_4_r <= 4'd9;
               end else begin
                  digit_1_r <= bcd_r[3:0];
                  digit_2_r <= bcd_r[7:4];
                  digit_3_r <= bcd_r[11:8];
                  digit_4_r <= bcd_r[15:12];
               end
               overflow_r <= overflow_s;
               done_r     <= 1'b1;
               busy_r     <= 1'b0;
               state_r    <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign o_Digit_1  = digit_1_r;
   assign o_Digit_2  = digit_2_r;
   assign o_Digit_3  = digit_3_r;
   assign o_Digit_4  = digit_4_r;
   assign o_Busy     = busy_r;
   assign o_Done     = done_r;
   assign o_Overflow = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_digits
//
// Self-checking bench for bin_to_bcd_digits (default 14-bit input). Expected
// digits come from plain decimal arithmetic on the input value.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_digits;

   localparam int W = 14;

   logic         i_Clk = 1'b0;
   logic         i_Reset;
   logic         i_Start;
   logic [W-1:0] i_Binary;
   logic [3:0]   o_Digit_1;
   logic [3:0]   o_Digit_2;
   logic [3:0]   o_Digit_3;
   logic [3:0]   o_Digit_4;
   logic         o_Busy;
   logic         o_Done;
   logic         o_Overflow;

   int n_total  = 0;
   int n_passed = 0;
   int n_failed = 0;

   logic [15:0] exp_digits_q;
   logic        exp_ovf_q;

   bin_to_bcd_digits #(.c_Input_Width(W)) dut (
      .i_Clk      (i_Clk),
      .i_Reset    (i_Reset),
      .i_Start    (i_Start),
      .i_Binary   (i_Binary),
      .o_Digit_1  (o_Digit_1),
      .o_Digit_2  (o_Digit_2),
      .o_Digit_3  (o_Digit_3),
      .o_Digit_4  (o_Digit_4),
      .o_Busy     (o_Busy),
      .o_Done     (o_Done),
      .o_Overflow (o_Overflow)
   );

   always #5 i_Clk = ~i_Clk;

   // Reference: decimal digits {thousands,hundreds,tens,ones}, 9999 on overflow.
   function automatic logic [15:0] model_digits(input int v);
      logic [15:0] r;
      if (v > 9999) begin
         r = 16'h9999;
      end else begin
         r = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      end
      return r;
   endfunction

   function automatic logic [15:0] dut_digits();
      return {o_Digit_4, o_Digit_3, o_Digit_2, o_Digit_1};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_passed++;
      end else begin
         n_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   // Full conversion: start, then wait (bounded) for the done pulse.
   task automatic run_conv(input int v, input string tag);
      int  n;
      bit  seen;
      i_Start  = 1'b1;
      i_Binary = W'(v);
      tick();                                   // edge 0
      check({tag, "_busy0"}, 32'(o_Busy), 32'd1);
      i_Start  = 1'b0;
      i_Binary = W'($urandom);                  // must not affect result
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         tick();
         n++;
         if (o_Done) begin
            seen = 1'b1;
         end else begin
            check({tag, "_hold"}, 32'(dut_digits()), 32'(exp_digits_q));
         end
      end
      check({tag, "_latency"}, 32'(n), 32'(W + 1));
      exp_digits_q = model_digits(v);
      exp_ovf_q    = (v > 9999);
      check({tag, "_digits"}, 32'(dut_digits()), 32'(exp_digits_q));
      check({tag, "_ovf"},    32'(o_Overflow),   32'(exp_ovf_q));
      check({tag, "_busyd"},  32'(o_Busy),       32'd0);
      tick();
      check({tag, "_pulse"},  32'(o_Done),       32'd0);
      check({tag, "_keep"},   32'(dut_digits()), 32'(exp_digits_q));
   endtask

   initial begin
      int dones;
      logic [15:0] got;
      int k;

      i_Reset  = 1'b1;
      i_Start  = 1'b0;
      i_Binary = '0;
      exp_digits_q = 16'h0000;
      exp_ovf_q    = 1'b0;
      tick();
      tick();
      i_Reset = 1'b0;
      check("rst_digits", 32'(dut_digits()), 32'h0);
      check("rst_busy",   32'(o_Busy),       32'd0);
      check("rst_done",   32'(o_Done),       32'd0);
      check("rst_ovf",    32'(o_Overflow),   32'd0);
      tick();

      // Directed conversions
      run_conv(1234,  "c1234");
      run_conv(0,     "c0");
      run_conv(9999,  "c9999");
      run_conv(10000, "c10000");
      run_conv(16383, "c16383");
      run_conv(42,    "c42");

      // Start ignored while busy
      i_Start  = 1'b1;
      i_Binary = W'(567);
      tick();                                   // edge 0
      i_Start = 1'b0;
      for (int i = 1; i <= 4; i++) tick();
      i_Start  = 1'b1;
      i_Binary = W'(8);
      tick();                                   // edge 5
      i_Start = 1'b0;
      dones = 0;
      got   = 16'h0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (o_Done) begin
            dones++;
            got = dut_digits();
         end
      end
      check("ign_dones",  32'(dones), 32'd1);
      check("ign_digits", 32'(got),   32'(model_digits(567)));
      exp_digits_q = model_digits(567);
      exp_ovf_q    = 1'b0;

      // Reset mid-conversion
      i_Start  = 1'b1;
      i_Binary = W'(4321);
      tick();                                   // edge 0
      i_Start = 1'b0;
      for (int i = 1; i <= 6; i++) tick();
      i_Reset = 1'b1;
      tick();                                   // edge 7
      i_Reset = 1'b0;
      check("mrst_digits", 32'(dut_digits()), 32'h0);
      check("mrst_busy",   32'(o_Busy),       32'd0);
      check("mrst_done",   32'(o_Done),       32'd0);
      check("mrst_ovf",    32'(o_Overflow),   32'd0);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (o_Done) dones++;
      end
      check("mrst_nodone", 32'(dones), 32'd0);
      exp_digits_q = 16'h0000;
      exp_ovf_q    = 1'b0;
      run_conv(50, "c50");

      // Start held high: back-to-back every W+2 cycles
      i_Start  = 1'b1;
      i_Binary = W'(305);
      tick();                                   // edge 0
      for (k = 1; k <= 3 * (W + 2); k++) begin
         tick();
         if (k % (W + 2) == W + 1) begin
            check("held_done",   32'(o_Done),       32'd1);
            check("held_busy",   32'(o_Busy),       32'd0);
            check("held_digits", 32'(dut_digits()), 32'(model_digits(305)));
         end else begin
            check("held_nodone", 32'(o_Done),       32'd0);
            check("held_busy1",  32'(o_Busy),       32'd1);
         end
      end
      i_Start = 1'b0;
      dones = 0;
      for (int i = 0; i < 40 && dones == 0; i++) begin
         tick();
         if (o_Done) dones++;
      end
      check("held_drain", 32'(dones), 32'd1);
      exp_digits_q = model_digits(305);
      exp_ovf_q    = 1'b0;
      tick();

      // Randomized values against the decimal model
      for (int r = 0; r < 20; r++) begin
         run_conv(int'($urandom_range(0, 16383)), "rand");
      end
      run_conv(int'($urandom_range(0, 9999)), "randlo");

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_digits.md
Name: bin_to_bcd_digits

Overview:
- Sequential double-dabble converter that turns an unsigned binary value into four BCD digits.
- Drives the four digit inputs of the 4-digit seven-segment display driver. Digit 1 is ones (rightmost anode), digit 4 is thousands.
- Outputs are registered and change only when a conversion completes, so the display never shows partial results.
- Sits between counters or measurement logic and the display driver.

Parameters:
- c_Input_Width, 14: width of i_Binary. Legal range 4..14. One shift cycle per bit.

Ports:
- i_Clk  input  1  system clock, all logic on rising edge
- i_Reset  input  1  synchronous, active-high reset
- i_Start  input  1  conversion request, sampled only in IDLE
- i_Binary  input  c_Input_Width  unsigned value to convert, captured on the accepted start edge
- o_Digit_1  output  4  ones digit, BCD 0..9
- o_Digit_2  output  4  tens digit
- o_Digit_3  output  4  hundreds digit
- o_Digit_4  output  4  thousands digit
- o_Busy  output  1  conversion in progress
- o_Done  output  1  one-cycle pulse: new digits valid
- o_Overflow  output  1  last converted value exceeded 9999

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset state:
  - state IDLE
  - all o_Digit_* = 0
  - o_Busy = 0, o_Done = 0, o_Overflow = 0
  - internal shift register and bit counter cleared
- Reset mid-conversion: aborts the conversion, no o_Done pulse, digits return to 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with i_Start = 1, capture i_Binary into the binary shift register.
  - Clear the 16-bit BCD accumulator and load bit counter = c_Input_Width.
  - Next state SHIFT; o_Busy goes 1 at that edge.
- SHIFT, one edge per input bit:
  - Each BCD nibble of the accumulator that is >= 5 gets +3, evaluated combinationally on the pre-shift value.
  - Then {accumulator, binary} shifts left by 1 and the counter decrements.
  - After c_Input_Width shift edges, next state DONE.
- DONE, single cycle. At its closing edge:
  - If the captured value > 9999: all four digits load 9 and o_Overflow loads 1.
  - Otherwise the digits load from accumulator nibbles [3:0],[7:4],[11:8],[15:12] and o_Overflow loads 0.
  - o_Done is registered high for exactly one cycle, o_Busy returns to 0 on the same edge, and the state returns to IDLE.
- Latency: start accepted at edge 0 → digits valid and o_Done high after edge c_Input_Width+1 (edge 15 at the default). o_Busy is high after edges 0..c_Input_Width.
- i_Start while busy (SHIFT or DONE) is ignored; no queuing. Changes to i_Binary after capture have no effect.
- A start held high through completion is accepted on the first IDLE edge, i.e. the edge after o_Done rises. Back-to-back conversions therefore run every c_Input_Width+2 cycles.
- Overflow is only reachable when c_Input_Width = 14. The overflow comparison uses the captured value, not a live input.
- o_Digit_* never exceed 9. Previous digits and o_Overflow hold between conversions.

Test Plan:
- Reset, then i_Start with i_Binary = 1234 → o_Busy high after edge 0; after edge 15: o_Done = 1 for one cycle, digits 4,3,2,1 (1..4), o_Overflow = 0.
- Convert 0 and then 9999 → digits 0,0,0,0 and then 9,9,9,9, o_Overflow = 0 both times; digits hold unchanged between o_Done pulses.
- Convert 10000, then 16383 → digits 9,9,9,9 with o_Overflow = 1 each time; a following conversion of 42 gives digits 2,4,0,0 and o_Overflow = 0.
- Start 567, then pulse i_Start with i_Binary = 8 at edge 5 → exactly one o_Done pulse; result digits 7,6,5,0.
- Start 4321, assert i_Reset at edge 7 → no o_Done, all outputs 0 next cycle. A new start of 50 then gives digits 0,5,0,0 after 15 edges.
- i_Start held high with i_Binary = 305 → o_Done pulses every 16 cycles, digits 5,0,3,0; o_Busy is low for exactly the o_Done cycle.
